// File: rtl/load_store_unit_if.sv
// load_store_unit_if: core request/response channel and memory port of the
// load/store unit. The slave modport is the LSU; the master modport is the
// surrounding core and memory.
interface load_store_unit_if;
    // Core request channel
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    // Core response channel
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    // Memory port
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [2:0]  mem_size;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_addr, req_wdata, rsp_ready, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_addr, mem_wdata, mem_we, mem_size
    );

    modport master (
        output req_valid, req_we, req_size, req_addr, req_wdata, rsp_ready, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_addr, mem_wdata, mem_we, mem_size
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: accepts one load/store from the core, checks it for
// legality, performs a single-cycle memory access and returns the result.
// Sign/zero extension and byte lane placement are done by the memory, which
// receives the access size on mem_size.
// Optional feature: define LSU_MISALIGN_TRAP_EN to reject misaligned halfword
// and word accesses; without it they reach memory unchanged.
module load_store_unit #(
    parameter int MEM_SIZE = 256
) (
    input  logic                    CLK,
    input  logic                    RESET,
    load_store_unit_if.slave        bus,
    output logic [15:0]             ld_count,
    output logic [15:0]             st_count
);

    localparam logic [2:0] SZ_WORD   = 3'b000;
    localparam logic [2:0] SZ_BYTE   = 3'b001;
    localparam logic [2:0] SZ_HALF   = 3'b010;
    localparam logic [2:0] SZ_BYTE_U = 3'b011;
    localparam logic [2:0] SZ_HALF_U = 3'b100;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [15:0] ld_cnt_q, ld_cnt_d;
    logic [15:0] st_cnt_q, st_cnt_d;

    logic [32:0] nbytes;
    logic [32:0] last_addr;
    logic        illegal;

    // Legality of the request currently presented by the core.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        nbytes  = 33'd1;
        illegal = 1'b0;
        case (bus.req_size)
            SZ_WORD:            nbytes = 33'd4;
            SZ_HALF, SZ_HALF_U: nbytes = 33'd2;
            default:            nbytes = 33'd1;
        endcase
        // 33-bit sum so an address near 2^32 cannot wrap back into range.
        last_addr = {1'b0, bus.req_addr} + nbytes - 33'd1;
        if (bus.req_size > SZ_HALF_U)
            illegal = 1'b1;
        if (bus.req_we && (bus.req_size == SZ_BYTE_U || bus.req_size == SZ_HALF_U))
            illegal = 1'b1;
        if (last_addr >= 33'(MEM_SIZE))
            illegal = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
        if ((bus.req_size == SZ_HALF || bus.req_size == SZ_HALF_U) && bus.req_addr[0])
            illegal = 1'b1;
        if (bus.req_size == SZ_WORD && bus.req_addr[1:0] != 2'b00)
            illegal = 1'b1;
`endif
    end

    // Next-state, request capture, result capture and counter update.
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        size_d   = size_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        ld_cnt_d = ld_cnt_q;
        st_cnt_d = st_cnt_q;
        case (state_q)
            IDLE: begin
                // req_ready is 1 throughout IDLE, so req_valid alone means acceptance.
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    size_d  = bus.req_size;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    rdata_d = 32'd0;
                    err_d   = illegal;
                    state_d = illegal ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                rdata_d = we_q ? 32'd0 : bus.mem_rdata;
                if (we_q) begin
                    if (st_cnt_q != 16'hFFFF) st_cnt_d = st_cnt_q + 16'd1;
                end else begin
                    if (ld_cnt_q != 16'hFFFF) ld_cnt_d = ld_cnt_q + 16'd1;
                end
                state_d = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset also drops any pending response.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            size_q   <= SZ_BYTE;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
            ld_cnt_q <= 16'd0;
            st_cnt_q <= 16'd0;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples the pre-edge values of the others.
            state_q  <= state_d;
            we_q     <= we_d;
            size_q   <= size_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            ld_cnt_q <= ld_cnt_d;
            st_cnt_q <= st_cnt_d;
        end
    end

    // Outputs decode straight from state so a reset removes mem_we at once.
    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_we    = (state_q == ACCESS) && we_q;
    assign bus.mem_size  = (state_q == ACCESS) ? size_q : SZ_BYTE;
    assign ld_count      = ld_cnt_q;
    assign st_count      = st_cnt_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table-driven bench for load_store_unit with a
// big-endian byte memory model, plus hand-written reset sequences.
module tb_load_store_unit;

    localparam int         MEM_SIZE  = 256;
    localparam logic [2:0] SZ_WORD   = 3'b000;
    localparam logic [2:0] SZ_BYTE   = 3'b001;
    localparam logic [2:0] SZ_HALF   = 3'b010;
    localparam logic [2:0] SZ_BYTE_U = 3'b011;
    localparam logic [2:0] SZ_HALF_U = 3'b100;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [15:0] ld_count, st_count;

    load_store_unit_if bus();

    load_store_unit #(.MEM_SIZE(MEM_SIZE)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .bus      (bus.slave),
        .ld_count (ld_count),
        .st_count (st_count)
    );

    always #5 CLK = ~CLK;

    // ---------------- memory model (big-endian, memory does extension) ----
    logic [7:0]  mem [0:MEM_SIZE-1];
    logic        mem_init = 1'b1;
    logic [7:0]  i0, i1, i2, i3;
    logic [31:0] rd;

    assign i0 = bus.mem_addr[7:0];
    assign i1 = i0 + 8'd1;
    assign i2 = i0 + 8'd2;
    assign i3 = i0 + 8'd3;

    always_comb begin
        rd = 32'd0;
        case (bus.mem_size)
            SZ_WORD:   rd = {mem[i0], mem[i1], mem[i2], mem[i3]};
            SZ_BYTE:   rd = {{24{mem[i0][7]}}, mem[i0]};
            SZ_BYTE_U: rd = {24'd0, mem[i0]};
            SZ_HALF:   rd = {{16{mem[i0][7]}}, mem[i0], mem[i1]};
            SZ_HALF_U: rd = {16'd0, mem[i0], mem[i1]};
            default:   rd = 32'd0;
        endcase
    end
    assign bus.mem_rdata = rd;

    always @(posedge CLK) begin
        if (mem_init) begin
            foreach (mem[k]) mem[k] <= 8'h00;
            mem[3]   <= 8'h93;
            mem[254] <= 8'h80;
            mem[255] <= 8'h7F;
        end else if (bus.mem_we) begin
            case (bus.mem_size)
                SZ_WORD: begin
                    mem[i0] <= bus.mem_wdata[31:24];
                    mem[i1] <= bus.mem_wdata[23:16];
                    mem[i2] <= bus.mem_wdata[15:8];
                    mem[i3] <= bus.mem_wdata[7:0];
                end
                SZ_HALF: begin
                    mem[i0] <= bus.mem_wdata[15:8];
                    mem[i1] <= bus.mem_wdata[7:0];
                end
                default: mem[i0] <= bus.mem_wdata[7:0];
            endcase
        end
    end

    int we_cycles = 0;
    always @(negedge CLK) if (bus.mem_we) we_cycles++;

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_bad = 0;
    int ld_exp = 0;
    int st_exp = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          hold;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic we, input logic [2:0] size, input logic [31:0] addr,
                                input logic [31:0] wdata, input int hold,
                                input logic exp_err, input logic [31:0] exp_rdata);
        vec_t v;
        v.we = we; v.size = size; v.addr = addr; v.wdata = wdata;
        v.hold = hold; v.exp_err = exp_err; v.exp_rdata = exp_rdata;
        return v;
    endfunction

    // Issue one request at a negedge and follow it to the end of its response.
    task automatic run_vec(input int idx, input vec_t v);
        int lat;
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge CLK);
        check({tag, ".req_ready"}, {31'd0, bus.req_ready}, 32'd1);
        we_cycles     = 0;
        bus.req_valid = 1'b1;
        bus.req_we    = v.we;
        bus.req_size  = v.size;
        bus.req_addr  = v.addr;
        bus.req_wdata = v.wdata;
        @(posedge CLK);
        @(negedge CLK);
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 8) begin
            @(negedge CLK);
            lat++;
        end
        check({tag, ".latency"}, lat, v.exp_err ? 32'd1 : 32'd2);
        check({tag, ".rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
        check({tag, ".rsp_err"}, {31'd0, bus.rsp_err}, {31'd0, v.exp_err});
        check({tag, ".rsp_rdata"}, bus.rsp_rdata, v.exp_rdata);
        for (int h = 0; h < v.hold; h++) begin
            @(negedge CLK);
            check({tag, ".hold_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
            check({tag, ".hold_rdata"}, bus.rsp_rdata, v.exp_rdata);
            check({tag, ".hold_err"}, {31'd0, bus.rsp_err}, {31'd0, v.exp_err});
            check({tag, ".hold_req_ready"}, {31'd0, bus.req_ready}, 32'd0);
        end
        bus.rsp_ready = 1'b1;
        check({tag, ".no_accept_on_complete"}, {31'd0, bus.req_ready}, 32'd0);
        @(negedge CLK);
        bus.rsp_ready = 1'b0;
        check({tag, ".rsp_valid_done"}, {31'd0, bus.rsp_valid}, 32'd0);
        check({tag, ".idle_again"}, {31'd0, bus.req_ready}, 32'd1);
        if (!v.exp_err) begin
            if (v.we) st_exp++;
            else      ld_exp++;
        end
        check({tag, ".we_cycles"}, we_cycles, (v.we && !v.exp_err) ? 32'd1 : 32'd0);
        check({tag, ".ld_count"}, {16'd0, ld_count}, ld_exp);
        check({tag, ".st_count"}, {16'd0, st_count}, st_exp);
    endtask

    logic        mis_err;
    logic [31:0] mis_rdata;

    initial begin
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_size  = SZ_WORD;
        bus.req_addr  = 32'd0;
        bus.req_wdata = 32'd0;
        bus.rsp_ready = 1'b0;

`ifdef LSU_MISALIGN_TRAP_EN
        mis_err   = 1'b1;
        mis_rdata = 32'h0000_0000;
`else
        mis_err   = 1'b0;
        mis_rdata = 32'h0093_0000;   // bytes 2..5 = 00 93 00 00
`endif

        //             we    size       addr      wdata         hold err   rdata
        vecs.push_back(mk(1'b0, SZ_WORD,   32'd0,   32'h0,         0, 1'b0, 32'h0000_0093));
        vecs.push_back(mk(1'b0, SZ_BYTE,   32'd3,   32'h0,         0, 1'b0, 32'hFFFF_FF93));
        vecs.push_back(mk(1'b0, SZ_BYTE_U, 32'd3,   32'h0,         2, 1'b0, 32'h0000_0093));
        vecs.push_back(mk(1'b1, SZ_HALF,   32'd40,  32'h1234_ABCD, 0, 1'b0, 32'h0));
        vecs.push_back(mk(1'b0, SZ_WORD,   32'd40,  32'h0,         0, 1'b0, 32'hABCD_0000));
        vecs.push_back(mk(1'b0, SZ_WORD,   32'd2,   32'h0,         0, mis_err, mis_rdata));
        vecs.push_back(mk(1'b1, SZ_BYTE_U, 32'd0,   32'h0000_00FF, 0, 1'b1, 32'h0));
        vecs.push_back(mk(1'b0, SZ_WORD,   32'd254, 32'h0,         3, 1'b1, 32'h0));
        vecs.push_back(mk(1'b0, SZ_WORD,   32'd253, 32'h0,         0, 1'b1, 32'h0));
        vecs.push_back(mk(1'b0, SZ_BYTE,   32'd255, 32'h0,         0, 1'b0, 32'h0000_007F));
        vecs.push_back(mk(1'b0, SZ_HALF,   32'd254, 32'h0,         0, 1'b0, 32'hFFFF_807F));
        vecs.push_back(mk(1'b0, SZ_HALF_U, 32'd254, 32'h0,         0, 1'b0, 32'h0000_807F));
        vecs.push_back(mk(1'b0, SZ_HALF,   32'd255, 32'h0,         0, 1'b1, 32'h0));
        vecs.push_back(mk(1'b0, 3'b101,    32'd0,   32'h0,         0, 1'b1, 32'h0));
        vecs.push_back(mk(1'b1, SZ_HALF_U, 32'd8,   32'h0000_1111, 0, 1'b1, 32'h0));
        vecs.push_back(mk(1'b1, SZ_WORD,   32'd8,   32'hDEAD_BEEF, 0, 1'b0, 32'h0));
        vecs.push_back(mk(1'b0, SZ_BYTE,   32'd9,   32'h0,         0, 1'b0, 32'hFFFF_FFAD));
        vecs.push_back(mk(1'b1, SZ_BYTE,   32'd11,  32'hFFFF_FF55, 0, 1'b0, 32'h0));
        vecs.push_back(mk(1'b0, SZ_WORD,   32'd8,   32'h0,         0, 1'b0, 32'hDEAD_BE55));

        // Reset state, sampled while RESET is still high.
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst.rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst.rsp_rdata", bus.rsp_rdata, 32'd0);
        check("rst.rsp_err",   {31'd0, bus.rsp_err}, 32'd0);
        check("rst.mem_we",    {31'd0, bus.mem_we}, 32'd0);
        check("rst.mem_addr",  bus.mem_addr, 32'd0);
        check("rst.mem_wdata", bus.mem_wdata, 32'd0);
        check("rst.mem_size",  {29'd0, bus.mem_size}, 32'd1);
        check("rst.ld_count",  {16'd0, ld_count}, 32'd0);
        check("rst.st_count",  {16'd0, st_count}, 32'd0);
        RESET    = 1'b0;
        mem_init = 1'b0;
        #1;
        check("rst.req_ready", {31'd0, bus.req_ready}, 32'd1);

        for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

        // Reset during the ACCESS cycle of a store.
        @(negedge CLK);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_size  = SZ_WORD;
        bus.req_addr  = 32'd100;
        bus.req_wdata = 32'hCAFE_F00D;
        @(posedge CLK);
        @(negedge CLK);
        bus.req_valid = 1'b0;
        check("racc.mem_we_before", {31'd0, bus.mem_we}, 32'd1);
        #2 RESET = 1'b1;
        #1;
        check("racc.mem_we",    {31'd0, bus.mem_we}, 32'd0);
        check("racc.rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("racc.idle",      {31'd0, bus.req_ready}, 32'd1);
        check("racc.ld_count",  {16'd0, ld_count}, 32'd0);
        check("racc.st_count",  {16'd0, st_count}, 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        ld_exp = 0;
        st_exp = 0;
        check("racc.mem_unwritten", {mem[100], mem[101], mem[102], mem[103]}, 32'd0);

        // Reset while a load response is waiting in RESP.
        @(negedge CLK);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_size  = SZ_BYTE_U;
        bus.req_addr  = 32'd3;
        @(posedge CLK);
        @(negedge CLK);
        bus.req_valid = 1'b0;
        @(negedge CLK);
        check("rrsp.valid_before", {31'd0, bus.rsp_valid}, 32'd1);
        check("rrsp.rdata_before", bus.rsp_rdata, 32'h0000_0093);
        #2 RESET = 1'b1;
        #1;
        check("rrsp.rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rrsp.rsp_rdata", bus.rsp_rdata, 32'd0);
        check("rrsp.ld_count",  {16'd0, ld_count}, 32'd0);
        @(negedge CLK);
        RESET = 1'b0;

        // The aborted store never reached memory; a fresh load still works.
        run_vec(100, mk(1'b0, SZ_WORD, 32'd100, 32'h0, 0, 1'b0, 32'h0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard time limit in case the DUT wedges somewhere unexpected.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, compared %0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
